regfile_param: RTL and testbench

Parametrised successor to the 2-read/1-write register file used by the datapath. Generalises data width and depth, and keeps the hardwired zero register as an option. Adds per-byte write enables, optional same-cycle write-to-read bypass, optional registered read outputs, and a multi-cycle sweep-clear engine that zeroes the array without asserting reset.

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_clear_seq.sv | 50 +++++
 rtl/regfile_param.sv | 108 ++++++++++
 tb/tb_regfile_param.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file and its sweep-clear sequencer.
package regfile_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_DEPTH      = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } sweepState_t;

   function automatic int clog2(input int value);
      int result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   // One byte lane of a masked write: take the new byte only where its enable is set.
   function automatic logic [7:0] byteMerge(input logic [7:0] oldByte,
                                            input logic [7:0] newByte,
                                            input logic       laneEn);
      return laneEn ? newByte : oldByte;
   endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Sweep-clear sequencer: walks every register index once, one per cycle, after a clear request.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int  DEPTH      = DEFAULT_DEPTH,
   localparam int ADDR_WIDTH = clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic                  ctrl_reset,
   input  logic                  ctrl_clear,
   output logic                  clear_busy,
   output logic                  clear_we,
   output logic [ADDR_WIDTH-1:0] clear_idx
);

   sweepState_t state;

   always_ff @(posedge clock) begin
      if (!ctrl_reset) begin
         state      <= IDLE;
         clear_busy <= 1'b0;
         clear_idx  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ctrl_clear) begin
                  state      <= SWEEP;
                  clear_busy <= 1'b1;
                  clear_idx  <= '0;
               end
            end
            SWEEP: begin
               // Index wraps to 0 naturally since DEPTH is a power of two.
               clear_idx <= clear_idx + 1'b1;
               if (clear_idx == ADDR_WIDTH'(DEPTH - 1)) begin
                  state      <= IDLE;
                  clear_busy <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               clear_busy <= 1'b0;
            end
         endcase
      end
   end

   assign clear_we = clear_busy;

endmodule

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with byte enables, optional bypass,
// optional registered reads and a sweep-clear engine.
module regfile_param
   import regfile_pkg::*;
#(
   parameter int  DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int  DEPTH        = DEFAULT_DEPTH,
   parameter int  ZERO_REG     = 1,
   parameter int  BYPASS       = 1,
   parameter int  READ_LATENCY = 0,
   localparam int ADDR_WIDTH   = clog2(DEPTH)
) (
   input  logic                    clock,
   input  logic                    ctrl_reset,
   input  logic                    ctrl_writeEn,
   input  logic [ADDR_WIDTH-1:0]   ctrl_writeReg,
   input  logic [DATA_WIDTH-1:0]   data_writeReg,
   input  logic [DATA_WIDTH/8-1:0] ctrl_byteEn,
   input  logic [ADDR_WIDTH-1:0]   ctrl_readRegA,
   input  logic [ADDR_WIDTH-1:0]   ctrl_readRegB,
   input  logic                    ctrl_clear,
   output logic [DATA_WIDTH-1:0]   data_readRegA,
   output logic [DATA_WIDTH-1:0]   data_readRegB,
   output logic                    clear_busy
);

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic [DATA_WIDTH-1:0] merged;
   logic [DATA_WIDTH-1:0] valA;
   logic [DATA_WIDTH-1:0] valB;
   logic                  writeCommit;
   logic                  clearWe;
   logic [ADDR_WIDTH-1:0] clearIdx;

   regfile_clear_seq #(.DEPTH(DEPTH)) clearSeq (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .ctrl_clear (ctrl_clear),
      .clear_busy (clear_busy),
      .clear_we   (clearWe),
      .clear_idx  (clearIdx)
   );

   assign writeCommit = ctrl_writeEn && !clear_busy &&
                        !((ZERO_REG != 0) && (ctrl_writeReg == '0));

   always_comb begin
      merged = '0;
      for (int i = 0; i < DATA_WIDTH / 8; i++) begin
         merged[8*i +: 8] = byteMerge(regs[ctrl_writeReg][8*i +: 8],
                                      data_writeReg[8*i +: 8], ctrl_byteEn[i]);
      end
   end

   always_ff @(posedge clock) begin
      if (!ctrl_reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (clearWe) begin
         regs[clearIdx] <= '0;
      end else if (writeCommit) begin
         regs[ctrl_writeReg] <= merged;
      end
   end

   // Bypass is naturally inactive during a sweep because writeCommit is held low.
   always_comb begin
      valA = regs[ctrl_readRegA];
      if ((ZERO_REG != 0) && (ctrl_readRegA == '0)) begin
         valA = '0;
      end else if ((BYPASS != 0) && writeCommit && (ctrl_readRegA == ctrl_writeReg)) begin
         valA = merged;
      end
   end

   always_comb begin
      valB = regs[ctrl_readRegB];
      if ((ZERO_REG != 0) && (ctrl_readRegB == '0)) begin
         valB = '0;
      end else if ((BYPASS != 0) && writeCommit && (ctrl_readRegB == ctrl_writeReg)) begin
         valB = merged;
      end
   end

   generate
      if (READ_LATENCY == 1) begin : gRegRead
         logic [DATA_WIDTH-1:0] readA_p1;
         logic [DATA_WIDTH-1:0] readB_p1;

         // p0 -> p1: read values captured at posedge
         always_ff @(posedge clock) begin
            if (!ctrl_reset) begin
               readA_p1 <= '0;
               readB_p1 <= '0;
            end else begin
               readA_p1 <= valA;
               readB_p1 <= valB;
            end
         end

         assign data_readRegA = readA_p1;
         assign data_readRegB = readB_p1;
      end else begin : gCombRead
         assign data_readRegA = valA;
         assign data_readRegB = valB;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: default, no-bypass and registered-read variants.
module tb_regfile_param;

   logic        clock = 1'b0;
   logic        ctrl_reset;
   logic        ctrl_writeEn;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic [3:0]  ctrl_byteEn;
   logic [4:0]  ctrl_readRegA;
   logic [4:0]  ctrl_readRegB;
   logic        ctrl_clear;

   logic [31:0] dataA, dataB, nbA, nbB, latA, latB;
   logic        busy, nbBusy, latBusy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] expA;
      logic [31:0] expB;
      string       name;
   } sbItem_t;
   sbItem_t sbQ[$];

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] exp;
      string       name;
   } vec_t;
   vec_t vecs[7];

   always #5 clock = ~clock;

   regfile_param dut (
      .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEn(ctrl_writeEn),
      .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg), .ctrl_byteEn(ctrl_byteEn),
      .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB), .ctrl_clear(ctrl_clear),
      .data_readRegA(dataA), .data_readRegB(dataB), .clear_busy(busy)
   );

   regfile_param #(.BYPASS(0)) dutNb (
      .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEn(ctrl_writeEn),
      .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg), .ctrl_byteEn(ctrl_byteEn),
      .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB), .ctrl_clear(ctrl_clear),
      .data_readRegA(nbA), .data_readRegB(nbB), .clear_busy(nbBusy)
   );

   regfile_param #(.READ_LATENCY(1)) dutLat (
      .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEn(ctrl_writeEn),
      .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg), .ctrl_byteEn(ctrl_byteEn),
      .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB), .ctrl_clear(ctrl_clear),
      .data_readRegA(latA), .data_readRegB(latB), .clear_busy(latBusy)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Advance to just after the next rising edge (the drive point).
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic writeReg(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      ctrl_writeEn  = 1'b1;
      ctrl_writeReg = a;
      data_writeReg = d;
      ctrl_byteEn   = be;
      cyc();
      ctrl_writeEn  = 1'b0;
   endtask

   // Combinational ports checked mid-cycle; registered port checked after the edge via the queue.
   task automatic readCycle(input logic [4:0] a, input logic [4:0] b,
                            input logic [31:0] ea, input logic [31:0] eb, input string nm);
      sbItem_t it;
      ctrl_readRegA = a;
      ctrl_readRegB = b;
      #4;
      check({nm, "/combA"}, dataA, ea);
      check({nm, "/combB"}, dataB, eb);
      check({nm, "/nbA"}, nbA, ea);
      check({nm, "/nbB"}, nbB, eb);
      it.expA = ea;
      it.expB = eb;
      it.name = nm;
      sbQ.push_back(it);
      cyc();
      if (sbQ.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s/scoreboard: got empty queue required one entry", nm);
      end else begin
         it = sbQ.pop_front();
         check({it.name, "/latA"}, latA, it.expA);
         check({it.name, "/latB"}, latB, it.expB);
      end
   endtask

   task automatic runSweep(input int writeAt, input int clearAt, input int resetAt,
                           output int busyCount);
      busyCount  = 0;
      ctrl_clear = 1'b1;
      cyc();
      ctrl_clear = 1'b0;
      for (int i = 0; i < 100 && busy; i++) begin
         busyCount++;
         ctrl_writeEn  = (busyCount == writeAt);
         ctrl_writeReg = 5'd3;
         data_writeReg = 32'h1;
         ctrl_byteEn   = 4'hF;
         ctrl_clear    = (busyCount == clearAt);
         ctrl_reset    = !(busyCount == resetAt);
         cyc();
      end
      ctrl_writeEn = 1'b0;
      ctrl_clear   = 1'b0;
      ctrl_reset   = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;

      ctrl_reset = 1'b0; ctrl_writeEn = 1'b0; ctrl_writeReg = '0; data_writeReg = '0;
      ctrl_byteEn = '0; ctrl_readRegA = 5'd3; ctrl_readRegB = 5'd4; ctrl_clear = 1'b0;
      cyc();
      cyc();
      check("reset/busy", {31'd0, busy}, 32'd0);
      check("reset/latA", latA, 32'd0);
      check("reset/latB", latB, 32'd0);
      ctrl_reset = 1'b1;

      for (int r = 0; r < 32; r++) readCycle(5'(r), 5'(r), 32'd0, 32'd0, $sformatf("rst_r%0d", r));

      for (int r = 1; r < 32; r++) writeReg(5'(r), 32'h0000DEAD, 4'hF);
      for (int r = 1; r < 32; r++)
         readCycle(5'(r), 5'(31 - r + 1), 32'h0000DEAD, 32'h0000DEAD, $sformatf("dead_r%0d", r));

      vecs[0] = '{5'd5,  32'h11223344, 4'hF,    32'h11223344, "be_full"};
      vecs[1] = '{5'd5,  32'hAABBCCDD, 4'b0101, 32'h11BB33DD, "be_0101"};
      vecs[2] = '{5'd5,  32'hFFFFFFFF, 4'b0000, 32'h11BB33DD, "be_none"};
      vecs[3] = '{5'd0,  32'hFFFFFFFF, 4'hF,    32'h00000000, "zero_reg"};
      vecs[4] = '{5'd9,  32'hCAFEF00D, 4'b1000, 32'hCA00DEAD, "be_1000"};
      vecs[5] = '{5'd31, 32'h12345678, 4'b0110, 32'h003456AD, "be_0110"};
      vecs[6] = '{5'd1,  32'hFFFFFFFF, 4'b0011, 32'h0000FFFF, "be_0011"};
      for (int v = 0; v < 7; v++) begin
         writeReg(vecs[v].addr, vecs[v].data, vecs[v].be);
         readCycle(vecs[v].addr, vecs[v].addr, vecs[v].exp, vecs[v].exp, vecs[v].name);
      end

      // Same-cycle write/read of r7: bypass on dut, old value on dutNb.
      ctrl_writeEn = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'h12345678; ctrl_byteEn = 4'hF;
      ctrl_readRegA = 5'd7; ctrl_readRegB = 5'd8;
      #4;
      check("bypass/A", dataA, 32'h12345678);
      check("bypass/B", dataB, 32'h0000DEAD);
      check("nobypass/A", nbA, 32'h0000DEAD);
      cyc();
      ctrl_writeEn = 1'b0;
      check("nobypass/after", nbA, 32'h12345678);
      check("bypass/latA", latA, 32'h12345678);
      ctrl_writeEn = 1'b1; ctrl_writeReg = 5'd0; data_writeReg = 32'hFFFFFFFF; ctrl_readRegA = 5'd0;
      #4;
      check("bypass/zero", dataA, 32'd0);
      cyc();
      ctrl_writeEn = 1'b0;

      // Registered read: value appears exactly one edge after the address.
      ctrl_readRegA = 5'd5;
      cyc();
      ctrl_readRegA = 5'd9;
      #4;
      check("lat/hold", latA, 32'h11BB33DD);
      cyc();
      check("lat/next", latA, 32'hCA00DEAD);

      for (int r = 1; r < 32; r++) writeReg(5'(r), 32'hA5A5A5A5, 4'hF);
      runSweep(20, 25, 0, cnt);
      check("sweep/busyCycles", 32'(cnt), 32'd32);
      check("sweep/busyAfter", {31'd0, busy}, 32'd0);
      for (int r = 0; r < 32; r++) readCycle(5'(r), 5'(r), 32'd0, 32'd0, $sformatf("swp_r%0d", r));

      writeReg(5'd20, 32'h55555555, 4'hF);
      ctrl_readRegA = 5'd20;
      runSweep(0, 0, 10, cnt);
      check("abort/busyCycles", 32'(cnt), 32'd10);
      check("abort/busy", {31'd0, busy}, 32'd0);
      check("abort/latA", latA, 32'd0);
      for (int r = 0; r < 32; r++) readCycle(5'(r), 5'(r), 32'd0, 32'd0, $sformatf("abt_r%0d", r));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
